// File: rtl/byte_serial_add_ctrl.sv
// Byte-serial WIDTH-bit add/subtract sequencer built around one 8-bit carry-lookahead slice.
// Operands are latched on accept and processed LSB byte first, one byte per cycle.

module eight_bit_adder (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] sum,
    output logic       g0,
    output logic       p0,
    output logic       c7
);
    logic [7:0] gen;
    logic [7:0] prop;
    logic       carry;
    logic       grp_gen;

    assign gen  = a & b;
    assign prop = a ^ b;
    assign p0   = &prop;

    // Carry chain with cin for the sum; group generate is the same chain seeded with 0.
    always_comb begin
        carry   = cin;
        grp_gen = 1'b0;
        sum     = '0;
        c7      = 1'b0;
        for (int i = 0; i < 8; i++) begin
            sum[i] = prop[i] ^ carry;
            if (i == 7) begin
                c7 = carry;
            end
            carry   = gen[i] | (prop[i] & carry);
            grp_gen = gen[i] | (prop[i] & grp_gen);
        end
        g0 = grp_gen;
    end
endmodule

module byte_serial_add_ctrl #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_sub,
    output logic [WIDTH-1:0] data_result,
    output logic             carry_out,
    output logic             overflow,
    output logic             result_valid
);
    localparam int unsigned SLICES = WIDTH / 8;
    localparam int unsigned IDX_W  = $clog2(SLICES);
    localparam int unsigned SH_W   = IDX_W + 3;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SLICES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   bx_q, bx_d;
    logic               carry_q, carry_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;

    logic [SH_W-1:0]    byte_sh;
    logic [7:0]         slice_a;
    logic [7:0]         slice_b;
    logic [7:0]         slice_sum;
    logic               slice_g0;
    logic               slice_p0;
    logic               slice_c7;
    logic               slice_cout;

    assign byte_sh    = {idx_q, 3'b000};
    assign slice_a    = 8'(a_q >> byte_sh);
    assign slice_b    = 8'(bx_q >> byte_sh);
    assign slice_cout = slice_g0 | (slice_p0 & carry_q);

    eight_bit_adder u_slice (
        .a   (slice_a),
        .b   (slice_b),
        .cin (carry_q),
        .sum (slice_sum),
        .g0  (slice_g0),
        .p0  (slice_p0),
        .c7  (slice_c7)
    );

    assign in_ready     = (state_q != BUSY);
    assign result_valid = (state_q == DONE);
    assign data_result  = result_q;
    assign carry_out    = cout_q;
    assign overflow     = ovf_q;

    // Next-state and datapath update.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        a_d      = a_q;
        bx_d     = bx_q;
        carry_d  = carry_q;
        result_d = result_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;

        case (state_q)
            IDLE, DONE: begin
                if (in_valid) begin
                    a_d     = data_operandA;
                    bx_d    = ctrl_sub ? ~data_operandB : data_operandB;
                    carry_d = ctrl_sub;
                    idx_d   = '0;
                    state_d = BUSY;
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                result_d = (result_q & ~(WIDTH'(8'hFF) << byte_sh))
                         | (WIDTH'(slice_sum) << byte_sh);
                carry_d  = slice_cout;
                if (idx_q == LAST_IDX) begin
                    cout_d  = slice_cout;
                    ovf_d   = slice_c7 ^ slice_cout;
                    idx_d   = '0;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: begin
                idx_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            a_q      <= '0;
            bx_q     <= '0;
            carry_q  <= 1'b0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            a_q      <= a_d;
            bx_q     <= bx_d;
            carry_q  <= carry_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
        end
    end
endmodule
